// File: rtl/armleocpu_tlb_ctrl.sv
// armleocpu_tlb_ctrl: shares one TLB between fetch and load/store, refills misses through the page-table walker
module armleocpu_tlb_ctrl #(
  parameter bit ARB_FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [39:0] req_vpn,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [21:0] rsp_ptag,
  output logic [7:0]  rsp_metadata,
  output logic        rsp_error,
  input  logic        inv_req,
  output logic        inv_ready,
  output logic [1:0]  tlb_cmd,
  output logic [19:0] tlb_vaddr,
  input  logic        tlb_hit,
  input  logic [7:0]  tlb_metadata,
  input  logic [21:0] tlb_ptag,
  output logic [7:0]  tlb_new_metadata,
  output logic [21:0] tlb_new_ptag,
  output logic        ptw_req_valid,
  output logic [19:0] ptw_req_vpn,
  input  logic        ptw_req_ready,
  input  logic        ptw_rsp_valid,
  input  logic        ptw_rsp_error,
  input  logic [7:0]  ptw_rsp_metadata,
  input  logic [21:0] ptw_rsp_ptag
);
  localparam logic [1:0] TLB_CMD_NONE = 2'd0, TLB_CMD_RESOLVE = 2'd1,
                         TLB_CMD_NEW_ENTRY = 2'd2, TLB_CMD_INVALIDATE_ALL = 2'd3;
  typedef enum logic [2:0] {IDLE, LOOKUP, PTW_REQ, PTW_WAIT, REFILL} state_t;
  state_t state;
  logic owner, last_grant, grant, walk_fault;
  logic [19:0] vpn_q, grant_vpn;
  logic [7:0] pte_meta_q;
  logic [21:0] pte_ptag_q;
  logic [1:0] owner_oh;
  assign grant = &req_valid ? (ARB_FIXED_PRIORITY ? 1'b0 : ~last_grant) : req_valid[1];
  assign grant_vpn = grant ? req_vpn[39:20] : req_vpn[19:0];
  assign owner_oh = owner ? 2'b10 : 2'b01;
  assign walk_fault = ptw_rsp_error | ~ptw_rsp_metadata[0];
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_ptag = '0;
    rsp_metadata = '0;
    rsp_error = 1'b0;
    inv_ready = 1'b0;
    tlb_cmd = TLB_CMD_NONE;
    tlb_vaddr = vpn_q;
    tlb_new_metadata = pte_meta_q;
    tlb_new_ptag = pte_ptag_q;
    ptw_req_valid = 1'b0;
    ptw_req_vpn = '0;
    unique case (state)
      // IDLE outputs come from live inputs, so keep them quiet while reset is held
      IDLE: if (rst_n) begin
        if (inv_req) begin
          tlb_cmd = TLB_CMD_INVALIDATE_ALL;
          inv_ready = 1'b1;
        end else if (|req_valid) begin
          req_ready = grant ? 2'b10 : 2'b01;
          tlb_cmd = TLB_CMD_RESOLVE;
          tlb_vaddr = grant_vpn;
        end
      end
      LOOKUP: if (tlb_hit) begin
        rsp_valid = owner_oh;
        rsp_ptag = tlb_ptag;
        rsp_metadata = tlb_metadata;
      end
      PTW_REQ: begin
        ptw_req_valid = 1'b1;
        ptw_req_vpn = vpn_q;
      end
      PTW_WAIT: if (ptw_rsp_valid && walk_fault) begin
        rsp_valid = owner_oh;
        rsp_error = 1'b1;
      end
      // a pending invalidate suppresses the install so no stale entry survives it
      REFILL: begin
        tlb_cmd = inv_req ? TLB_CMD_NONE : TLB_CMD_NEW_ENTRY;
        rsp_valid = owner_oh;
        rsp_ptag = pte_ptag_q;
        rsp_metadata = pte_meta_q;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last_grant <= 1'b1;
      vpn_q <= '0;
      pte_meta_q <= '0;
      pte_ptag_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (!inv_req && |req_valid) begin
          state <= LOOKUP;
          owner <= grant;
          last_grant <= grant;
          vpn_q <= grant_vpn;
        end
        LOOKUP: state <= tlb_hit ? IDLE : PTW_REQ;
        PTW_REQ: if (ptw_req_ready) state <= PTW_WAIT;
        PTW_WAIT: if (ptw_rsp_valid) begin
          pte_meta_q <= ptw_rsp_metadata;
          pte_ptag_q <= ptw_rsp_ptag;
          state <= walk_fault ? IDLE : REFILL;
        end
        REFILL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_armleocpu_tlb_ctrl.sv
// tb_armleocpu_tlb_ctrl: randomized and directed checks against a transaction-level model of the controller
module tb_armleocpu_tlb_ctrl;
  localparam logic [1:0] NONE = 2'd0, RES = 2'd1, NEW = 2'd2, INV = 2'd3;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] rv;
  logic [19:0] vpn_in [2];
  logic [1:0] req_ready, rsp_valid, tlb_cmd;
  logic [21:0] rsp_ptag, tlb_ptag, tlb_new_ptag, ptw_rsp_ptag;
  logic [7:0] rsp_metadata, tlb_metadata, tlb_new_metadata, ptw_rsp_metadata;
  logic rsp_error, inv_req, inv_ready, tlb_hit, ptw_req_valid, ptw_req_ready, ptw_rsp_valid, ptw_rsp_error;
  logic [19:0] tlb_vaddr, ptw_req_vpn;
  logic [1:0] f_ready, f_rsp_valid, f_cmd;
  logic [21:0] f_ptag, f_new_ptag;
  logic [7:0] f_meta, f_new_meta;
  logic f_err, f_inv_ready, f_ptw_valid;
  logic [19:0] f_vaddr, f_ptw_vpn;
  int total = 0, bad = 0;
  int rdy_lat = -1, rsp_lat = -1;
  logic hs;
  logic [1:0] outst;

  always #5 clk = ~clk;

  armleocpu_tlb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_vpn({vpn_in[1], vpn_in[0]}),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ptag(rsp_ptag), .rsp_metadata(rsp_metadata),
    .rsp_error(rsp_error), .inv_req(inv_req), .inv_ready(inv_ready), .tlb_cmd(tlb_cmd),
    .tlb_vaddr(tlb_vaddr), .tlb_hit(tlb_hit), .tlb_metadata(tlb_metadata), .tlb_ptag(tlb_ptag),
    .tlb_new_metadata(tlb_new_metadata), .tlb_new_ptag(tlb_new_ptag), .ptw_req_valid(ptw_req_valid),
    .ptw_req_vpn(ptw_req_vpn), .ptw_req_ready(ptw_req_ready), .ptw_rsp_valid(ptw_rsp_valid),
    .ptw_rsp_error(ptw_rsp_error), .ptw_rsp_metadata(ptw_rsp_metadata), .ptw_rsp_ptag(ptw_rsp_ptag)
  );

  armleocpu_tlb_ctrl #(.ARB_FIXED_PRIORITY(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n), .req_valid(2'b11), .req_vpn(40'h0),
    .req_ready(f_ready), .rsp_valid(f_rsp_valid), .rsp_ptag(f_ptag), .rsp_metadata(f_meta),
    .rsp_error(f_err), .inv_req(1'b0), .inv_ready(f_inv_ready), .tlb_cmd(f_cmd),
    .tlb_vaddr(f_vaddr), .tlb_hit(1'b1), .tlb_metadata(8'h0), .tlb_ptag(22'h0),
    .tlb_new_metadata(f_new_meta), .tlb_new_ptag(f_new_ptag), .ptw_req_valid(f_ptw_valid),
    .ptw_req_vpn(f_ptw_vpn), .ptw_req_ready(1'b0), .ptw_rsp_valid(1'b0),
    .ptw_rsp_error(1'b0), .ptw_rsp_metadata(8'h0), .ptw_rsp_ptag(22'h0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // page table contents as {error, metadata, ptag}
  function automatic logic [30:0] pt(input logic [19:0] v);
    if (v == 20'h12345) return {1'b0, 8'hCF, 22'h3ABCD};
    if (v == 20'h00042) return {1'b0, 8'h0F, 22'h00777};
    if (v[3:0] == 4'h3) return {1'b1, 8'h0F, 22'h0};
    if (v[3:0] == 4'h5) return {1'b0, 8'h0E, 22'h1};
    return {1'b0, v[7:1], 1'b1, 2'b01, v};
  endfunction

  function automatic logic [19:0] pick();
    logic [19:0] pool [8] = '{20'h12345, 20'h00042, 20'h00103, 20'h00205,
                              20'h0ABC7, 20'h0ABC8, 20'hFFFFF, 20'h00000};
    return pool[$urandom_range(0, 7)];
  endfunction

  // TLB: resolve result visible the cycle after RESOLVE, cleared by reset
  logic [29:0] tlb_mem [logic [19:0]];
  initial begin
    tlb_hit = 1'b0; tlb_metadata = '0; tlb_ptag = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) tlb_mem.delete();
      else if (tlb_cmd == RES) begin
        tlb_hit = tlb_mem.exists(tlb_vaddr) != 0;
        {tlb_metadata, tlb_ptag} = tlb_hit ? tlb_mem[tlb_vaddr] : 30'h0;
      end else if (tlb_cmd == NEW) tlb_mem[tlb_vaddr] = {tlb_new_metadata, tlb_new_ptag};
      else if (tlb_cmd == INV) tlb_mem.delete();
    end
  end

  logic [19:0] pv;
  initial begin
    ptw_req_ready = 0; ptw_rsp_valid = 0; ptw_rsp_error = 0; ptw_rsp_metadata = '0; ptw_rsp_ptag = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && ptw_req_valid) begin
        pv = ptw_req_vpn;
        repeat (rdy_lat < 0 ? int'($urandom_range(0, 3)) : rdy_lat) begin @(posedge clk); #1; end
        ptw_req_ready = 1;
        @(posedge clk); #1;
        ptw_req_ready = 0;
        repeat (rsp_lat < 0 ? int'($urandom_range(0, 4)) : rsp_lat) begin @(posedge clk); #1; end
        {ptw_rsp_error, ptw_rsp_metadata, ptw_rsp_ptag} = pt(pv);
        ptw_rsp_valid = 1;
        @(posedge clk); #1;
        ptw_rsp_valid = 0;
      end
    end
  end

  // reference: one transaction at a time, a set of cached translations, round-robin pointer
  logic pend, p_owner, hit_exp, walked, ref_last;
  logic [19:0] p_vpn;
  int cyc, acc_cyc, prsp_cyc;
  logic [29:0] cache [logic [19:0]];
  initial begin
    logic ge;
    logic [1:0] exp_rdy;
    logic [30:0] e;
    logic [29:0] c;
    pend = 0; p_owner = 0; hit_exp = 0; walked = 0; ref_last = 1; p_vpn = '0;
    cyc = 0; acc_cyc = 0; prsp_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend = 0; ref_last = 1; cache.delete();
      end else if (!pend) begin
        ge = &rv ? !ref_last : rv[1];
        exp_rdy = (!inv_req && |rv) ? (ge ? 2'b10 : 2'b01) : 2'b00;
        check("req_ready", req_ready, exp_rdy);
        check("inv_ready", inv_ready, inv_req);
        check("idle_rsp", rsp_valid, 0);
        check("idle_ptw", ptw_req_valid, 0);
        if (inv_req) begin
          check("inv_cmd", tlb_cmd, INV);
          cache.delete();
        end else if (|rv) begin
          check("res_cmd", tlb_cmd, RES);
          check("res_vaddr", tlb_vaddr, vpn_in[ge]);
          pend = 1; p_owner = ge; p_vpn = vpn_in[ge]; hit_exp = cache.exists(p_vpn) != 0;
          walked = 0; acc_cyc = cyc; ref_last = ge;
        end else check("idle_cmd", tlb_cmd, NONE);
      end else begin
        check("busy_accept", {req_ready, inv_ready}, 0);
        if (ptw_req_valid) begin
          check("ptw_on_hit", hit_exp, 0);
          check("ptw_vpn", ptw_req_vpn, p_vpn);
          if (ptw_req_ready) walked = 1;
        end else if (walked && ptw_rsp_valid) prsp_cyc = cyc;
        if (|rsp_valid) begin
          check("rsp_owner", rsp_valid, p_owner ? 2'b10 : 2'b01);
          if (hit_exp) begin
            c = cache[p_vpn];
            check("hit_lat", cyc - acc_cyc, 1);
            check("hit_walk", walked, 0);
            check("hit_ptag", rsp_ptag, c[21:0]);
            check("hit_meta", rsp_metadata, c[29:22]);
            check("hit_err", rsp_error, 0);
          end else begin
            e = pt(p_vpn);
            check("miss_walk", walked, 1);
            if (e[30] || !e[22]) begin
              check("fault_err", rsp_error, 1);
              check("fault_lat", cyc - prsp_cyc, 0);
              check("fault_cmd", tlb_cmd, NONE);
              check("fault_data", {rsp_metadata, rsp_ptag}, 0);
            end else begin
              check("refill_err", rsp_error, 0);
              check("refill_lat", cyc - prsp_cyc, 1);
              check("refill_ptag", rsp_ptag, e[21:0]);
              check("refill_meta", rsp_metadata, e[29:22]);
              check("refill_cmd", tlb_cmd, inv_req ? NONE : NEW);
              check("refill_vaddr", tlb_vaddr, p_vpn);
              check("refill_new", {tlb_new_metadata, tlb_new_ptag}, e[29:0]);
              if (!inv_req) cache[p_vpn] = e[29:0];
            end
          end
          pend = 0;
        end
      end
    end
  end

  initial begin
    int k = 0, n = 0;
    @(posedge rst_n);
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (|f_ready) begin
        check("fixed_grant", f_ready, 2'b01);
        k++;
      end
    end
    check("fixed_count", k, 4);
  end

  task automatic step(input bit gen);
    logic [1:0] acc;
    logic inv_ack;
    @(negedge clk);
    hs = ptw_req_valid && ptw_req_ready;
    acc = req_ready;
    outst = outst & ~rsp_valid;
    inv_ack = inv_ready;
    @(posedge clk); #1;
    outst = outst | acc;
    rv = rv & ~acc;
    if (inv_ack) inv_req = 0;
    if (gen) begin
      for (int r = 0; r < 2; r++)
        if (!rv[r] && !outst[r] && $urandom_range(0, 2) == 0) begin
          rv[r] = 1'b1;
          vpn_in[r] = pick();
        end
      if (!inv_req && $urandom_range(0, 39) == 0) inv_req = 1;
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin
      step(0);
      n++;
    end while ((|rv || |outst || inv_req) && n < 300);
    check("drain_timeout", n < 300, 1);
  endtask

  task automatic issue(input int r, input logic [19:0] v);
    rv[r] = 1'b1;
    vpn_in[r] = v;
    drain();
  endtask

  task automatic check_reset_outputs();
    check("rst_rsp", {rsp_valid, rsp_error, |rsp_ptag, |rsp_metadata}, 0);
    check("rst_accept", {req_ready, inv_ready}, 0);
    check("rst_cmd", tlb_cmd, NONE);
    check("rst_vaddr", tlb_vaddr, 0);
    check("rst_new", {|tlb_new_metadata, |tlb_new_ptag}, 0);
    check("rst_ptw", {ptw_req_valid, |ptw_req_vpn}, 0);
  endtask

  task automatic wait_walk(input string tag);
    int n = 0;
    do begin
      step(0);
      n++;
    end while (!hs && n < 50);
    check(tag, hs, 1);
  endtask

  initial begin
    rst_n = 0; rv = 2'b11; inv_req = 1; outst = '0; hs = 0;
    vpn_in[0] = 20'h12345; vpn_in[1] = 20'h00042;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rv = '0; inv_req = 0;
    rst_n = 1;
    issue(0, 20'h12345);
    issue(0, 20'h12345);
    rdy_lat = 3;
    issue(1, 20'h00042);
    issue(1, 20'h00042);
    rdy_lat = -1;
    issue(0, 20'h00103);
    issue(0, 20'h00103);
    issue(0, 20'h00205);
    issue(0, 20'h00205);
    repeat (2) begin
      rv = 2'b11; vpn_in[0] = 20'h12345; vpn_in[1] = 20'h00042;
      drain();
    end
    // invalidate arriving while the walk is outstanding
    rsp_lat = 3;
    rv[1] = 1'b1; vpn_in[1] = 20'h0ABC8;
    wait_walk("inv_race_walk");
    inv_req = 1;
    drain();
    issue(1, 20'h0ABC8);
    rsp_lat = -1;
    repeat (1500) step(1);
    drain();
    // reset while the walker still owes a response
    rsp_lat = 12;
    rv[0] = 1'b1; vpn_in[0] = 20'h3C3C9;
    wait_walk("rst_walk");
    rst_n = 0;
    rv = 2'b11; inv_req = 1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rv = '0; inv_req = 0; outst = '0;
    rst_n = 1;
    repeat (20) step(0);
    rsp_lat = -1;
    rv = 2'b11; vpn_in[0] = 20'h3C3CA; vpn_in[1] = 20'h3C3CB;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
